// File: rtl/stepper_phase_seq.sv
// Stepper coil phase sequencer driven by the pulse generator's square wave.
// Full/half-step sequencing, step counting and programmable step target.
module stepper_phase_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic             dir,
  input  logic             half_step,
  input  logic [CNT_W-1:0] target,
  input  logic             clear,
  output logic [3:0]       coil,
  output logic [CNT_W-1:0] step_count,
  output logic             step_strobe,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [2:0]       idx;
  logic             pulse_d;
  logic [CNT_W-1:0] tgt;

  logic             rise;
  logic [2:0]       stride;
  logic [2:0]       idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hit;

  function automatic logic [3:0] seq(
    input logic [2:0] i
  );
    logic [3:0] p;
    p = 4'b0000;
    unique case (i)
      3'd0: p = 4'b0001;
      3'd1: p = 4'b0011;
      3'd2: p = 4'b0010;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0100;
      3'd5: p = 4'b1100;
      3'd6: p = 4'b1000;
      3'd7: p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  assign rise = pulse_in & ~pulse_d;

  // Next phase index: even indices in full-step move by one to reach an
  // odd (two-coil) phase, odd indices jump two to stay two-coil.
  always_comb begin
    stride = 3'd1;
    if (!half_step && idx[0])
      stride = 3'd2;
    idx_nxt = dir ? idx + stride : idx - stride;
    cnt_nxt = step_count + CNT_ONE;
    hit = (tgt != '0) && (cnt_nxt == tgt);
  end

  // Delayed copy of the step clock for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst)
      pulse_d <= 1'b0;
    else
      pulse_d <= pulse_in;
  end

  // Run-control FSM with coil, counter and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 3'd1;
      step_count  <= '0;
      coil        <= 4'b0000;
      step_strobe <= 1'b0;
      tgt         <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      idx         <= 3'd1;
      step_count  <= '0;
      coil        <= 4'b0000;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (enable) begin
            state <= S_RUN;
            tgt   <= target;
            coil  <= seq(idx);
          end else begin
            coil  <= 4'b0000;
          end
        end
        (state == S_RUN): begin
          if (!enable) begin
            state <= S_IDLE;
            coil  <= 4'b0000;
          end else if (rise) begin
            idx         <= idx_nxt;
            step_count  <= cnt_nxt;
            step_strobe <= 1'b1;
            coil        <= seq(idx_nxt);
            if (hit)
              state <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (!enable) begin
            state <= S_IDLE;
            coil  <= 4'b0000;
          end
        end
        default: begin
          state <= S_IDLE;
          coil  <= 4'b0000;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: doc/stepper_phase_seq.md
Name: stepper_phase_seq

Overview:
- Downstream consumer of the motor pulse generator's pulse_out square wave.
- Each rising edge of that wave advances a 4-coil stepper motor by one full step or one half step, in the selected direction.
- Counts the steps taken, stops after a programmable step target, and drives the coil outputs and step count seen by the display logic.

Parameters:
- CNT_W, 16, width of step_count and target.

Ports:
- clk  input  1  system clock, same domain as the pulse generator.
- rst  input  1  synchronous, active-high reset.
- pulse_in  input  1  step clock square wave (pulse_out of the pulse generator); registered in the clk domain.
- enable  input  1  level; run request.
- dir  input  1  1 = forward (index increments), 0 = reverse (index decrements).
- half_step  input  1  1 = half-step sequence, 0 = full-step (two-phase-on) sequence.
- target  input  CNT_W  number of steps to take; 0 = free-run.
- clear  input  1  synchronous clear of count, phase and state.
- coil  output  4  coil drive pattern {D,C,B,A}.
- step_count  output  CNT_W  steps taken since the last clear or reset.
- step_strobe  output  1  one-cycle pulse per step taken.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset: synchronous, active-high.
  - state = IDLE, phase index = 1, pulse_d = 0, step_count = 0.
  - coil = 0000, step_strobe = 0, busy = 0, done = 0, latched target = 0.
- Edge detect:
  - pulse_d <= pulse_in every cycle.
  - edge = pulse_in & ~pulse_d.
  - Exactly one edge per pulse_in rising transition. High time does not matter.
- Sequence table, index 0..7:
  - 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Coil output in RUN/DONE is table[index], registered.
- Step advance, on edge in RUN only:
  - Half-step: index ± 1, mod 8.
  - Full-step with odd index: index ± 2, mod 8.
  - Full-step with even index: index ± 1, mod 8, so it lands on odd.
  - Sign comes from dir.
  - dir and half_step are sampled only in the edge cycle.
- Latency:
  - Edge detected at posedge N; coil, step_count and step_strobe update at posedge N (visible after N).
  - That is one clk after pulse_in is first sampled high.
- FSM:
  - IDLE: coil = 0000. If enable = 1, go to RUN, latch target, coil = table[index]. An edge in the transition cycle is ignored.
  - RUN:
    - On edge: take step, step_count + 1, step_strobe = 1.
    - If latched target ≠ 0 and the new count == latched target: go to DONE.
    - enable = 0: go to IDLE, count and index retained, coil = 0000.
    - If enable = 0 and edge occur in the same cycle: go to IDLE, no step taken.
  - DONE:
    - Coil holds its last pattern (holding torque). Edges are ignored.
    - enable = 0: go to IDLE.
    - Re-arming requires enable low then high; the latched target is compared against the running count.
- clear:
  - Priority: below rst, above everything else.
  - Effect: step_count = 0, index = 1, state = IDLE, coil = 0000, step_strobe = 0.
  - clear and edge in the same cycle: clear wins, no step.
- Arithmetic:
  - step_count is unsigned CNT_W and wraps 2^CNT_W−1 → 0 (free-run only).
  - Target compare uses the incremented value.
- target changes after latching are ignored until the next IDLE→RUN.
- busy = (state == RUN); done = (state == DONE). Both registered with state.
- rst asserted mid-RUN: next cycle all outputs are at their reset values.

Test Plan:
1. Reset; enable = 1, dir = 1, half_step = 0, target = 0; 5 pulse_in rising edges → coil 0011 → 0110 → 1100 → 1001 → 0011 → 0110; step_count = 5; 5 single-cycle step_strobe pulses; busy = 1.
2. half_step = 1, dir = 0, index = 1, target = 3 → coil 0001, 1001, 1000; done = 1 with step_count = 3; a 4th edge leaves coil = 1000 and count = 3.
3. Mode switch: half-step forward to index 2 (0010), then half_step = 0 with one edge → index 3, coil 0110; next edge → 1100.
4. Hold pulse_in high for 40 cycles → exactly one step. Edge coinciding with the IDLE→RUN cycle → no step. Edge with clear asserted in the same cycle → count 0, coil 0000, state IDLE.
5. CNT_W = 4, free-run, 17 edges → step_count wraps to 1. enable dropped mid-run → coil = 0000, count held; re-enable → coil restores the last pattern.
6. rst asserted in RUN with count = 7 → next cycle coil = 0000, step_count = 0, busy = 0, done = 0, index = 1.
